// File: rtl/dot_frame_buffer_if.sv
// Write/commit/scan bus of the double-buffered dot-matrix frame store.
interface dot_frame_buffer_if #(
  parameter int unsigned COLS = 14
);
  logic            wr_en;
  logic [3:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic            clear;
  logic            commit;
  logic            frame_sync;
  logic [3:0]      rd_row;
  logic [COLS-1:0] rd_data;
  logic            busy;
  logic            swap_done;

  modport master (
    output wr_en, wr_row, wr_data, clear, commit, frame_sync, rd_row,
    input  rd_data, busy, swap_done
  );

  modport slave (
    input  wr_en, wr_row, wr_data, clear, commit, frame_sync, rd_row,
    output rd_data, busy, swap_done
  );
endinterface

// File: rtl/dot_frame_buffer.sv
// Double-buffered ROWS x COLS frame store; banks swap only on the scanner's
// frame boundary so a displayed frame is never torn.
module dot_frame_buffer #(
  parameter int unsigned ROWS = 10,
  parameter int unsigned COLS = 14
) (
  input logic               clk,
  input logic               rst,
  dot_frame_buffer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEARING, PENDING} state_t;

  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic            front;
  logic            back;
  logic            wr_hit;
  logic            clr_hit;
  logic            swap;
  logic [COLS-1:0] bank [2][ROWS];

  assign back     = ~front;
  assign bus.busy = (state != IDLE);

  // Next-state and per-cycle storage actions.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr_hit  = 1'b0;
    clr_hit = 1'b0;
    swap    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end else begin
          wr_hit = bus.wr_en && (bus.wr_row <= ROW_LAST);
          if (bus.commit) state_d = PENDING;
        end
      end
      CLEARING: begin
        clr_hit = 1'b1;
        cnt_d   = cnt + 4'd1;
        if (cnt == ROW_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      PENDING: begin
        if (bus.frame_sync) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and clear-row counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Bank select toggle and one-cycle swap acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front         <= 1'b0;
      bus.swap_done <= 1'b0;
    end else begin
      if (swap) front <= ~front;
      bus.swap_done <= swap;
    end
  end

  // Back-bank writes: clear rows take priority over host writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned r = 0; r < ROWS; r++)
          bank[b][r] <= '0;
    end else if (clr_hit) begin
      bank[back][cnt] <= '0;
    end else if (wr_hit) begin
      bank[back][bus.wr_row] <= bus.wr_data;
    end
  end

  // Registered front-bank read; the old front is still used on the swap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data <= '0;
    end else if (bus.rd_row <= ROW_LAST) begin
      bus.rd_data <= bank[front][bus.rd_row];
    end else begin
      bus.rd_data <= '0;
    end
  end

endmodule
